load_store_unit: RTL and testbench

//  Bridges the processor core's data-memory port and the data memory.

---
 rtl/load_store_unit.sv | 213 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Core data-port to data-memory bridge with byte lanes, load
//           extension, fault detection and a BUSY-state timeout.
// Rev     : 1.0
// ============================================================================
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_SIZE     = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  // The counter only has to reach TIMEOUT_CYCLES-1, so clog2 of the limit is enough.
  localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 1) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rd_q, rd_d;
  logic [1:0]        cause_q, cause_d;

  logic              timeout_hit;
  logic [1:0]        req_cause;

  function automatic logic [1:0] access_fault(input logic [2:0] size, input logic [1:0] a);
    case (size)
      SZ_B, SZ_BU: access_fault = CAUSE_NONE;
      SZ_H, SZ_HU: access_fault = a[0] ? CAUSE_MISALIGN : CAUSE_NONE;
      SZ_W:        access_fault = (a != 2'b00) ? CAUSE_MISALIGN : CAUSE_NONE;
      default:     access_fault = CAUSE_SIZE;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] a);
    case (size)
      SZ_B, SZ_BU: byte_enables = 4'b0001 << a;
      SZ_H, SZ_HU: byte_enables = 4'b0011 << {a[1], 1'b0};
      SZ_W:        byte_enables = 4'b1111;
      default:     byte_enables = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      SZ_B, SZ_BU: store_lanes = {4{wd[7:0]}};
      SZ_H, SZ_HU: store_lanes = {2{wd[15:0]}};
      default:     store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0]  size,
                                              input logic [1:0]  a,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    load_extend = {{24{b[7]}}, b};
      SZ_BU:   load_extend = {24'd0, b};
      SZ_H:    load_extend = {{16{h[15]}}, h};
      SZ_HU:   load_extend = {16'd0, h};
      SZ_W:    load_extend = rd;
      default: load_extend = 32'd0;
    endcase
  endfunction

  assign req_cause = access_fault(core_size_i, core_addr_i[1:0]);

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      assign timeout_hit = (cnt_q == CNT_LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    cause_d = cause_q;

    case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          we_d   = core_we_i;
          size_d = core_size_i;
          addr_d = core_addr_i;
          wd_d   = core_wd_i;
          cnt_d  = '0;
          // Faults skip the memory entirely and report straight from DONE.
          if (req_cause != CAUSE_NONE) begin
            state_d = S_DONE;
            cause_d = req_cause;
            rd_d    = 32'd0;
          end else begin
            state_d = S_BUSY;
            cause_d = CAUSE_NONE;
          end
        end
      end
      S_BUSY: begin
        if (mem_ready_i) begin
          state_d = S_DONE;
          cause_d = CAUSE_NONE;
          rd_d    = we_q ? 32'd0 : load_extend(size_q, addr_q[1:0], mem_rd_i);
        end else if (timeout_hit) begin
          state_d = S_DONE;
          cause_d = CAUSE_TIMEOUT;
          rd_d    = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      cnt_q   <= '0;
      rd_q    <= 32'd0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      cause_q <= cause_d;
    end
  end

  // Memory-side outputs are decoded from state so reset removes the request at once.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = 4'b0000;
    mem_addr_o = 32'd0;
    mem_wd_o   = 32'd0;
    if (state_q == S_BUSY) begin
      mem_req_o  = 1'b1;
      mem_we_o   = we_q;
      mem_be_o   = byte_enables(size_q, addr_q[1:0]);
      mem_addr_o = addr_q;
      mem_wd_o   = store_lanes(size_q, wd_q);
    end
  end

  assign core_stall_o = core_req_i & (state_q != S_DONE);
  assign core_rd_o    = rd_q;
  assign err_o        = (state_q == S_DONE) && (cause_q != CAUSE_NONE);
  assign err_cause_o  = (state_q == S_DONE) ? cause_q : CAUSE_NONE;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Scoreboard bench for load_store_unit with a behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, core_rd_o;
  logic        core_stall_o, err_o;
  logic [1:0]  err_cause_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
  logic        mem_ready_i;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .err_o(err_o), .err_cause_o(err_cause_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
    .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit        we;
    bit [3:0]  be;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [31:0] rd;
    bit [1:0]  cause;
    int        stall;
    int        busy;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_err = 0, n_done = 0;
  int          stall_cnt = 0, busy_cnt = 0, busy_idx = 0;
  bit          mon_en = 0;
  int          resp_wait = 0;
  bit [31:0]   resp_data = 0;

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: size gives a byte count; lanes, extension and latency follow arithmetically.
  function automatic exp_t model(input bit we, input bit [2:0] sz, input bit [31:0] a,
                                 input bit [31:0] wd, input bit [31:0] rdat, input int wt);
    exp_t   e;
    int     nb, off;
    bit     sgn;
    longint v, m;
    case (sz)
      3'd0: begin nb = 1; sgn = 1; end
      3'd1: begin nb = 2; sgn = 1; end
      3'd2: begin nb = 4; sgn = 0; end
      3'd4: begin nb = 1; sgn = 0; end
      3'd5: begin nb = 2; sgn = 0; end
      default: begin nb = 0; sgn = 0; end
    endcase
    e.we = we; e.addr = a; e.rd = 0; e.be = 0; e.wd = 0;
    if (nb == 0)               e.cause = 2;
    else if (a % nb != 0)      e.cause = 1;
    else if (wt >= TMO)        e.cause = 3;
    else                       e.cause = 0;
    if (nb != 0) begin
      off  = ((a % 4) / nb) * nb;
      e.be = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++)
        e.wd = e.wd | (((wd >> (8 * (i % nb))) & 32'hFF) << (8 * i));
      m = (64'd1 << (8 * nb)) - 1;
      v = longint'(rdat >> (8 * off)) & m;
      if (sgn && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
      if (!we && e.cause == 0) e.rd = v[31:0];
    end
    if (e.cause == 1 || e.cause == 2) e.busy = 0;
    else                              e.busy = (wt >= TMO) ? TMO : wt + 1;
    e.stall = 1 + e.busy;
    return e;
  endfunction

  // Memory responder: ready on BUSY cycle index resp_wait; random noise otherwise.
  initial begin
    mem_ready_i = 0;
    mem_rd_i    = 0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        mem_ready_i = (busy_idx == resp_wait);
        mem_rd_i    = mem_ready_i ? resp_data : $urandom;
        busy_idx++;
      end else begin
        busy_idx    = 0;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rd_i    = $urandom;
      end
    end
  end

  // Monitor: checks memory-side fields each BUSY cycle and the core response at completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        if (mem_req_o) begin
          busy_cnt++;
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL mem_req_unexpected: got 1 expected 0 at %0t", $time);
          end else if (sb[0].cause == 0 || sb[0].cause == 3) begin
            chk("mem_we",   {31'd0, mem_we_o}, {31'd0, sb[0].we});
            chk("mem_be",   {28'd0, mem_be_o}, {28'd0, sb[0].be});
            chk("mem_addr", mem_addr_o, sb[0].addr);
            if (sb[0].we) chk("mem_wd", mem_wd_o, sb[0].wd);
          end
        end
        if (core_req_i && core_stall_o) begin
          stall_cnt++;
          chk("err_outside_done", {29'd0, err_o, err_cause_o}, 32'd0);
        end else if (core_req_i && !core_stall_o) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL done_unexpected: got 1 expected 0 at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk("core_rd",   core_rd_o, e.rd);
            chk("err_o",     {31'd0, err_o}, {31'd0, (e.cause != 0)});
            chk("err_cause", {30'd0, err_cause_o}, {30'd0, e.cause});
            chk("stall_cycles", stall_cnt, e.stall);
            chk("busy_cycles",  busy_cnt, e.busy);
          end
          stall_cnt = 0;
          busy_cnt  = 0;
          n_done++;
        end
      end
    end
  end

  // Called in IDLE just after a rising edge; returns just after the edge leaving DONE.
  task automatic access(input bit we, input bit [2:0] sz, input bit [31:0] a,
                        input bit [31:0] wd, input bit [31:0] rdat, input int wt);
    int d0;
    int guard;
    sb.push_back(model(we, sz, a, wd, rdat, wt));
    resp_wait   = wt;
    resp_data   = rdat;
    d0          = n_done;
    core_req_i  = 1;
    core_we_i   = we;
    core_size_i = sz;
    core_addr_i = a;
    core_wd_i   = wd;
    guard       = 0;
    while (n_done == d0 && guard < 64) begin
      @(negedge clk_i);
      #2;
      guard++;
    end
    if (n_done == d0) begin
      $display("FAIL access_timeout: got no completion expected one within 64 cycles");
      $fatal(1);
    end
    @(posedge clk_i);
    #1;
    core_req_i = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

  initial begin
    bit [2:0]  sz;
    bit [31:0] a;
    int        wt;
    rst_ni = 0; core_req_i = 0; core_we_i = 0; core_size_i = 0;
    core_addr_i = 0; core_wd_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_req",  {31'd0, mem_req_o}, 32'd0);
    chk("rst_stall",    {31'd0, core_stall_o}, 32'd0);
    chk("rst_core_rd",  core_rd_o, 32'd0);
    chk("rst_err",      {29'd0, err_o, err_cause_o}, 32'd0);
    chk("rst_mem_be",   {28'd0, mem_be_o}, 32'd0);
    rst_ni = 1;
    @(posedge clk_i); #1;
    mon_en = 1;

    access(0, 3'd0, 32'h0000_0103, 32'h0,         32'h8011_2233, 0);    // LB
    access(1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 32'h0,         3);    // SH
    access(0, 3'd2, 32'h0000_0101, 32'h0,         32'h1234_5678, 0);    // LW misaligned
    access(0, 3'd3, 32'h0000_0100, 32'h0,         32'h1234_5678, 0);    // illegal size
    access(0, 3'd2, 32'h0000_0300, 32'h0,         32'h1234_5678, 1000); // timeout
    access(0, 3'd5, 32'h0000_0002, 32'h0,         32'h8001_FFFF, 0);    // LHU

    // Asynchronous reset in the middle of a BUSY access.
    mon_en      = 0;
    resp_wait   = 1000;
    core_req_i  = 1; core_we_i = 0; core_size_i = 3'd2; core_addr_i = 32'h40;
    repeat (3) @(negedge clk_i);
    #2;
    chk("pre_reset_busy", {31'd0, mem_req_o}, 32'd1);
    rst_ni = 0;
    #1;
    chk("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("reset_stall_req1", {31'd0, core_stall_o}, 32'd1);
    chk("reset_core_rd", core_rd_o, 32'd0);
    core_req_i = 0;
    #1;
    chk("reset_stall_req0", {31'd0, core_stall_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i); #1;
    chk("post_reset_stall0", {31'd0, core_stall_o}, 32'd0);
    chk("post_reset_mem_req", {31'd0, mem_req_o}, 32'd0);
    sb.delete();
    stall_cnt = 0;
    busy_cnt  = 0;
    mon_en    = 1;

    for (int n = 0; n < 300; n++) begin
      sz = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
      if ($urandom_range(0, 2) == 0) a[1] = 1'b0;
      wt = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 5));
      access(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom, wt);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end

    repeat (3) @(posedge clk_i);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
